// File: rtl/spi_slave.sv
// SPI slave in the system clock domain: oversampled nCS/DCLK/MOSI, all four SPI modes,
// one-entry tx queue with valid/ready, rx byte strobe, underrun and abort pulses.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       nCS,
    input  logic       DCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_oe,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       tx_underrun,
    output logic       frame_abort
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic [SYNC_STAGES-1:0] dclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] flush_q;

    state_e     state_q;
    logic       ncs_prev_q;
    logic       dclk_prev_q;
    logic       cpol_q;
    logic       cpha_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_shift_q;
    logic [7:0] rx_data_q;
    logic [7:0] tx_shift_q;
    logic [7:0] queue_q;
    logic [7:0] queue_d;
    logic       queue_full_q;
    logic       queue_full_d;
    logic       tx_ready_q;
    logic       rx_valid_q;
    logic       underrun_q;
    logic       abort_q;
    logic       busy_q;
    logic       miso_oe_q;

    logic       ncs_s;
    logic       dclk_s;
    logic       mosi_s;
    logic       sync_ok_s;
    logic       dclk_edge_s;
    logic       lead_s;
    logic       trail_s;
    logic       sample_s;
    logic       shift_s;
    logic       start_s;
    logic       stop_s;
    logic       done_s;
    logic       load_s;
    logic       capture_s;
    logic [7:0] load_byte_s;
    logic       underrun_s;

    // Synchronizer chains; flush_q marks when the chains hold only post-reset pin samples.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ncs_sync_q  <= '1;
            dclk_sync_q <= '0;
            mosi_sync_q <= '0;
            flush_q     <= '0;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
            dclk_sync_q <= {dclk_sync_q[SYNC_STAGES-2:0], DCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign dclk_s    = dclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sync_ok_s = flush_q[SYNC_STAGES-1];

    assign dclk_edge_s = (dclk_s != dclk_prev_q) && (state_q == ACTIVE) && !ncs_s;
    assign lead_s      = dclk_edge_s && (dclk_s != cpol_q);
    assign trail_s     = dclk_edge_s && (dclk_s == cpol_q);
    assign sample_s    = cpha_q ? trail_s : lead_s;
    assign shift_s     = cpha_q ? lead_s : trail_s;
    // A select only counts once nCS has been seen high after reset, so a reset mid-frame stays idle.
    assign start_s     = (state_q == IDLE) && sync_ok_s && ncs_prev_q && !ncs_s;
    assign stop_s      = (state_q == ACTIVE) && ncs_s;
    assign done_s      = sample_s && (bit_cnt_q == 3'd7);
    assign load_s      = start_s || done_s;
    assign capture_s   = tx_valid && tx_ready_q;

    // Tx byte selection and queue next state; a capture coinciding with a load bypasses the queue.
    always_comb begin
        load_byte_s  = IDLE_FILL;
        underrun_s   = 1'b0;
        queue_full_d = queue_full_q;
        queue_d      = queue_q;
        if (load_s) begin
            if (capture_s) begin
                load_byte_s = tx_data;
            end else if (queue_full_q) begin
                load_byte_s  = queue_q;
                queue_full_d = 1'b0;
            end else begin
                underrun_s = 1'b1;
            end
        end else if (capture_s) begin
            queue_d      = tx_data;
            queue_full_d = 1'b1;
        end else begin
            queue_full_d = queue_full_q;
        end
    end

    // Frame FSM, shift registers, tx queue and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ncs_prev_q   <= 1'b0;
            dclk_prev_q  <= 1'b0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 8'h00;
            rx_data_q    <= 8'h00;
            tx_shift_q   <= IDLE_FILL;
            queue_q      <= 8'h00;
            queue_full_q <= 1'b0;
            tx_ready_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
        end else begin
            ncs_prev_q   <= sync_ok_s & ncs_s;
            dclk_prev_q  <= dclk_s;
            queue_q      <= queue_d;
            queue_full_q <= queue_full_d;
            tx_ready_q   <= !queue_full_d;
            rx_valid_q   <= 1'b0;
            underrun_q   <= underrun_s;
            abort_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        state_q   <= ACTIVE;
                        cpol_q    <= CPOL;
                        cpha_q    <= CPHA;
                        busy_q    <= 1'b1;
                        miso_oe_q <= 1'b1;
                        bit_cnt_q <= 3'd0;
                    end
                end
                ACTIVE: begin
                    if (stop_s) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        abort_q   <= (bit_cnt_q != 3'd0);
                        bit_cnt_q <= 3'd0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                end
            endcase

            if (sample_s) begin
                rx_shift_q <= {rx_shift_q[6:0], mosi_s};
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                if (done_s) begin
                    rx_data_q  <= {rx_shift_q[6:0], mosi_s};
                    rx_valid_q <= 1'b1;
                end
            end

            // The first shift edge of a byte is skipped: its MSB is already on MISO.
            if (load_s) begin
                tx_shift_q <= load_byte_s;
            end else if (shift_s && (bit_cnt_q != 3'd0)) begin
                tx_shift_q <= {tx_shift_q[6:0], tx_shift_q[7]};
            end
        end
    end

    assign MISO        = tx_shift_q[7];
    assign MISO_oe     = miso_oe_q;
    assign busy        = busy_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: an SPI master drives frames in all modes; a queue-based model of the
// tx queue and load points predicts MISO bytes, rx bytes and pulse counts.
module tb_spi_slave;

    localparam int HALF = 8;

    logic       sys_clk;
    logic       rst;
    logic       nCS;
    logic       DCLK;
    logic       MOSI;
    logic       MISO;
    logic       MISO_oe;
    logic       CPOL;
    logic       CPHA;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;
    logic       frame_abort;

    spi_slave #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
        .sys_clk(sys_clk), .rst(rst), .nCS(nCS), .DCLK(DCLK), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .CPOL(CPOL), .CPHA(CPHA),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .tx_underrun(tx_underrun), .frame_abort(frame_abort)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    int n_rxv = 0;
    int n_und = 0;
    int n_abt = 0;
    logic [7:0] rx_got[$];

    logic [7:0] model_q[$];
    logic [7:0] refill_q[$];
    logic [7:0] mb[4];

    always @(negedge sys_clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_rxv++;
                rx_got.push_back(rx_data);
            end
            if (tx_underrun) n_und++;
            if (frame_abort) n_abt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic model_load(output logic [7:0] b, inout int u);
        if (model_q.size() > 0) begin
            b = model_q.pop_front();
        end else begin
            b = 8'hFF;
            u++;
        end
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            wait_clk(1);
            n++;
        end
        chk("push_ready", 32'(tx_ready), 32'(1'b1));
        tx_data  = b;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        model_q.push_back(b);
        chk("ready_drop", 32'(tx_ready), 32'(1'b0));
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (CPHA == 1'b0) begin
                MOSI = mo[7-i];
                wait_clk(HALF);
                mi   = {mi[6:0], MISO};
                DCLK = ~CPOL;
                wait_clk(HALF);
                DCLK = CPOL;
            end else begin
                wait_clk(HALF);
                DCLK = ~CPOL;
                MOSI = mo[7-i];
                wait_clk(HALF);
                mi   = {mi[6:0], MISO};
                DCLK = CPOL;
            end
        end
        wait_clk(HALF / 2);
    endtask

    // nb full bytes from mb[], then a partial byte of last_bits bits (0 = none) which aborts the frame.
    task automatic run_frame(input logic [1:0] mode, input int nb, input int last_bits);
        logic [7:0] exp_b;
        logic [7:0] mi;
        logic [7:0] mask;
        int rx0, und0, ab0, und_exp;
        rx0 = n_rxv; und0 = n_und; ab0 = n_abt; und_exp = 0;
        rx_got.delete();
        CPOL = mode[1];
        CPHA = mode[0];
        DCLK = mode[1];
        wait_clk(4);
        nCS = 1'b0;
        wait_clk(HALF);
        chk("busy_sel", 32'(busy), 32'(1'b1));
        chk("oe_sel", 32'(MISO_oe), 32'(1'b1));
        model_load(exp_b, und_exp);
        chk("underrun_at_select", 32'(n_und - und0), 32'(und_exp));
        if (refill_q.size() > 0) push(refill_q.pop_front());
        for (int k = 0; k < nb; k++) begin
            xfer(mb[k], 8, mi);
            chk("miso_byte", 32'(mi), 32'(exp_b));
            model_load(exp_b, und_exp);
            if (refill_q.size() > 0) push(refill_q.pop_front());
        end
        if (last_bits > 0) begin
            xfer(mb[nb], last_bits, mi);
            mask = 8'((9'd1 << last_bits) - 9'd1);
            chk("miso_partial", 32'(mi & mask), 32'(exp_b >> (8 - last_bits)));
        end
        wait_clk(HALF);
        nCS = 1'b1;
        wait_clk(HALF);
        chk("busy_desel", 32'(busy), 32'(1'b0));
        chk("oe_desel", 32'(MISO_oe), 32'(1'b0));
        chk("rx_count", 32'(n_rxv - rx0), 32'(nb));
        for (int k = 0; k < nb; k++) begin
            chk("rx_byte", (k < rx_got.size()) ? 32'(rx_got[k]) : 32'hDEAD, 32'(mb[k]));
        end
        if (nb > 0) chk("rx_hold", 32'(rx_data), 32'(mb[nb-1]));
        chk("underrun_count", 32'(n_und - und0), 32'(und_exp));
        chk("abort_count", 32'(n_abt - ab0), (last_bits > 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [7:0] mi;
        int r0, a0, u0;
        rst = 1'b1; nCS = 1'b1; DCLK = 1'b0; MOSI = 1'b0;
        CPOL = 1'b0; CPHA = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        wait_clk(5);
        chk("rst_tx_ready", 32'(tx_ready), 32'(1'b0));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_oe", 32'(MISO_oe), 32'(1'b0));
        chk("rst_rx_valid", 32'(rx_valid), 32'(1'b0));
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_miso", 32'(MISO), 32'(1'b1));
        chk("rst_pulses", 32'({tx_underrun, frame_abort}), 32'(2'b00));
        rst = 1'b0;
        wait_clk(1);
        chk("ready_after_rst", 32'(tx_ready), 32'(1'b1));
        wait_clk(4);

        // A5 out, 3C in, in every mode
        for (int m = 0; m < 4; m++) begin
            push(8'hA5);
            mb[0] = 8'h3C;
            run_frame(2'(m), 1, 0);
        end

        // Two-byte frame with refills keeping the queue fed
        push(8'h11);
        refill_q.push_back(8'h22);
        refill_q.push_back(8'h33);
        mb[0] = 8'($urandom);
        mb[1] = 8'($urandom);
        run_frame(2'd0, 2, 0);

        // Empty queue at select
        mb[0] = 8'($urandom);
        run_frame(2'($urandom_range(0, 3)), 1, 0);

        // Abort after 5 bits; byte queued during the frame must survive to the next one
        refill_q.push_back(8'h96);
        mb[0] = 8'($urandom);
        run_frame(2'($urandom_range(0, 3)), 0, 5);
        mb[0] = 8'($urandom);
        run_frame(2'($urandom_range(0, 3)), 1, 0);

        // Randomized frames
        for (int f = 0; f < 4; f++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) mb[k] = 8'($urandom);
            if (model_q.size() == 0 && $urandom_range(0, 1) == 1) push(8'($urandom));
            for (int k = 0; k < int'($urandom_range(0, nb)); k++) refill_q.push_back(8'($urandom));
            run_frame(2'($urandom_range(0, 3)), nb, 0);
        end

        // Reset in the middle of a byte
        push(8'h5A);
        CPOL = 1'b0; CPHA = 1'b0; DCLK = 1'b0;
        wait_clk(4);
        nCS = 1'b0;
        wait_clk(HALF);
        xfer(8'hC3, 4, mi);
        rst = 1'b1;
        wait_clk(1);
        chk("mid_rst_busy", 32'(busy), 32'(1'b0));
        chk("mid_rst_oe", 32'(MISO_oe), 32'(1'b0));
        chk("mid_rst_ready", 32'(tx_ready), 32'(1'b0));
        chk("mid_rst_rx_data", 32'(rx_data), 32'h00);
        chk("mid_rst_miso", 32'(MISO), 32'(1'b1));
        chk("mid_rst_pulses", 32'({rx_valid, tx_underrun, frame_abort}), 32'(3'b000));
        model_q.delete();
        rst = 1'b0;
        r0 = n_rxv; a0 = n_abt; u0 = n_und;
        xfer(8'h0F, 4, mi);
        wait_clk(HALF);
        chk("post_rst_idle", 32'(busy), 32'(1'b0));
        nCS = 1'b1;
        wait_clk(HALF);
        chk("post_rst_no_rx", 32'(n_rxv - r0), 32'd0);
        chk("post_rst_no_abort", 32'(n_abt - a0), 32'd0);
        chk("post_rst_no_underrun", 32'(n_und - u0), 32'd0);
        chk("post_rst_ready", 32'(tx_ready), 32'(1'b1));
        push(8'hE7);
        mb[0] = 8'($urandom);
        run_frame(2'd3, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
